// File: rtl/deparser_layer_stream.sv
// One deparser layer: rule lookup on type fields, metadata write-back, header shift, next offsets.
// Two-stage pipeline (2-cycle latency); one global enable freezes both stages while the output is held.
module deparser_layer_stream #(
  parameter int HEAD_WIDTH = 512,
  parameter int META_WIDTH = 256,
  parameter int TYPE_WIDTH = 16,
  parameter int TYPE_NUM   = 2,
  parameter int KEY_WIDTH  = 16,
  parameter int KEY_NUM    = 4,
  parameter int RULE_NUM   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [HEAD_WIDTH-1:0]   i_head,
  input  logic [META_WIDTH-1:0]   i_meta,
  input  logic [TYPE_NUM*8-1:0]   i_type_offset,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [HEAD_WIDTH-1:0]   o_head,
  output logic [META_WIDTH-1:0]   o_meta,
  output logic [TYPE_NUM*8-1:0]   o_type_offset,
  output logic                    o_miss,
  input  logic                    i_rule_wren,
  input  logic                    i_rule_rden,
  input  logic [31:0]             i_rule_addr,
  input  logic [31:0]             i_rule_wdata,
  output logic                    o_rule_rdata_valid,
  output logic [31:0]             o_rule_rdata
);

  localparam int HW  = HEAD_WIDTH / KEY_WIDTH;
  localparam int MW  = META_WIDTH / KEY_WIDTH;
  localparam int TW  = HEAD_WIDTH / TYPE_WIDTH;
  localparam int KW  = TYPE_NUM * TYPE_WIDTH;
  localparam int KB  = KEY_NUM * 8;
  localparam int TB  = TYPE_NUM * 8;
  localparam int HWL = (HW < 256) ? HW : 256;
  localparam int MWL = (MW < 256) ? MW : 256;
  localparam int TWL = (TW < 256) ? TW : 256;

  // Rule table
  logic [RULE_NUM-1:0][KW-1:0] value_q, mask_q;
  logic [RULE_NUM-1:0]         vld_q;
  logic [RULE_NUM-1:0][7:0]    shift_q;
  logic [RULE_NUM-1:0][KEY_NUM-1:0] keyv_q;
  logic [RULE_NUM-1:0][KB-1:0] dst_q, src_q;
  logic [RULE_NUM-1:0][TB-1:0] nxt_q;
  logic [RULE_NUM-1:0][31:0]   hit_cnt_q;
  logic [31:0]                 miss_cnt_q;

  // Pipeline state
  logic                  s1_vld_q, s1_hit_q;
  logic [HEAD_WIDTH-1:0] s1_head_q;
  logic [META_WIDTH-1:0] s1_meta_q;
  logic [RULE_NUM-1:0]   s1_oh_q;
  logic [7:0]            s1_shift_q;
  logic [KEY_NUM-1:0]    s1_keyv_q;
  logic [KB-1:0]         s1_dst_q, s1_src_q;
  logic [TB-1:0]         s1_nxt_q;
  logic                  o_valid_q, o_miss_q;
  logic [HEAD_WIDTH-1:0] o_head_q;
  logic [META_WIDTH-1:0] o_meta_q;
  logic [TB-1:0]         o_toff_q;
  logic                  rvld_q;
  logic [31:0]           rdata_q;

  logic en, cnt_step, cfg_wr, miss_clr;
  logic [4:0] a_rule;
  logic [2:0] a_word;
  logic unused_bits;

  assign en       = !o_valid_q || i_ready;
  assign o_ready  = en;
  assign cnt_step = en && s1_vld_q;
  assign a_rule   = i_rule_addr[7:3];
  assign a_word   = i_rule_addr[2:0];
  assign cfg_wr   = i_rule_wren && !i_rule_addr[8];
  assign miss_clr = i_rule_wren && i_rule_addr[8] && (i_rule_addr[7:0] == 8'd0);
  assign unused_bits = &{1'b0, i_rule_addr[31:9], i_rule_wdata};

  assign o_valid            = o_valid_q;
  assign o_head             = o_head_q;
  assign o_meta             = o_meta_q;
  assign o_type_offset      = o_toff_q;
  assign o_miss             = o_miss_q;
  assign o_rule_rdata_valid = rvld_q;
  assign o_rule_rdata       = rdata_q;

  // Type field extraction; offsets beyond the window leave the field at zero
  logic [KW-1:0] key;
  always_comb begin
    key = '0;
    for (int i = 0; i < TYPE_NUM; i++) begin
      for (int w = 0; w < TWL; w++) begin
        if (i_type_offset[i*8 +: 8] == 8'(w))
          key[KW-1-i*TYPE_WIDTH -: TYPE_WIDTH] = i_head[HEAD_WIDTH-1-w*TYPE_WIDTH -: TYPE_WIDTH];
      end
    end
  end

  logic [RULE_NUM-1:0] hit_oh;
  logic                found;
  logic [7:0]          a_shift;
  logic [KEY_NUM-1:0]  a_keyv;
  logic [KB-1:0]       a_dst, a_src;
  logic [TB-1:0]       a_nxt;
  always_comb begin
    hit_oh  = '0;
    found   = 1'b0;
    a_shift = '0;
    a_keyv  = '0;
    a_dst   = '0;
    a_src   = '0;
    a_nxt   = '0;
    for (int r = 0; r < RULE_NUM; r++) begin
      if (!found && vld_q[r] && (((key ^ value_q[r]) & mask_q[r]) == '0)) begin
        found     = 1'b1;
        hit_oh[r] = 1'b1;
        a_shift   = shift_q[r];
        a_keyv    = keyv_q[r];
        a_dst     = dst_q[r];
        a_src     = src_q[r];
        a_nxt     = nxt_q[r];
      end
    end
  end

  // Replace then shift; keys applied in ascending order so the higher key wins a shared dst
  logic [HEAD_WIDTH-1:0] head_d;
  logic [TB-1:0]         toff_d;
  logic                  miss_d, src_ok;
  logic [KEY_WIDTH-1:0]  src_w;
  logic [31:0]           sh_bits;
  always_comb begin
    head_d  = s1_head_q;
    toff_d  = '0;
    miss_d  = s1_vld_q && !s1_hit_q;
    src_ok  = 1'b0;
    src_w   = '0;
    sh_bits = '0;
    if (s1_hit_q) begin
      toff_d = s1_nxt_q;
      for (int k = 0; k < KEY_NUM; k++) begin
        src_ok = 1'b0;
        src_w  = '0;
        for (int m = 0; m < MWL; m++) begin
          if (s1_src_q[k*8 +: 8] == 8'(m)) begin
            src_ok = 1'b1;
            src_w  = s1_meta_q[META_WIDTH-1-m*KEY_WIDTH -: KEY_WIDTH];
          end
        end
        for (int w = 0; w < HWL; w++) begin
          if (s1_keyv_q[k] && src_ok && (s1_dst_q[k*8 +: 8] == 8'(w)))
            head_d[HEAD_WIDTH-1-w*KEY_WIDTH -: KEY_WIDTH] = src_w;
        end
      end
      sh_bits = 32'(s1_shift_q) * KEY_WIDTH;
      head_d  = (32'(s1_shift_q) >= HW) ? '0 : (head_d << sh_bits);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_q   <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_head_q  <= '0;
      s1_meta_q  <= '0;
      s1_oh_q    <= '0;
      s1_shift_q <= '0;
      s1_keyv_q  <= '0;
      s1_dst_q   <= '0;
      s1_src_q   <= '0;
      s1_nxt_q   <= '0;
      o_valid_q  <= 1'b0;
      o_head_q   <= '0;
      o_meta_q   <= '0;
      o_toff_q   <= '0;
      o_miss_q   <= 1'b0;
    end else if (en) begin
      s1_vld_q   <= i_valid;
      s1_hit_q   <= found;
      s1_head_q  <= i_head;
      s1_meta_q  <= i_meta;
      s1_oh_q    <= hit_oh;
      s1_shift_q <= a_shift;
      s1_keyv_q  <= a_keyv;
      s1_dst_q   <= a_dst;
      s1_src_q   <= a_src;
      s1_nxt_q   <= a_nxt;
      o_valid_q  <= s1_vld_q;
      o_head_q   <= head_d;
      o_meta_q   <= s1_meta_q;
      o_toff_q   <= toff_d;
      o_miss_q   <= miss_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value_q    <= '0;
      mask_q     <= '0;
      vld_q      <= '0;
      shift_q    <= '0;
      keyv_q     <= '0;
      dst_q      <= '0;
      src_q      <= '0;
      nxt_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (cfg_wr && (a_rule == 5'(r))) begin
          case (a_word)
            3'd0: value_q[r] <= i_rule_wdata[KW-1:0];
            3'd1: mask_q[r]  <= i_rule_wdata[KW-1:0];
            3'd2: begin
              vld_q[r]   <= i_rule_wdata[31];
              shift_q[r] <= i_rule_wdata[15:8];
              keyv_q[r]  <= i_rule_wdata[KEY_NUM-1:0];
            end
            3'd3: dst_q[r] <= i_rule_wdata[KB-1:0];
            3'd4: src_q[r] <= i_rule_wdata[KB-1:0];
            3'd5: nxt_q[r] <= i_rule_wdata[TB-1:0];
            default: ;
          endcase
        end
        if (cfg_wr && (a_rule == 5'(r)) && (a_word == 3'd6))
          hit_cnt_q[r] <= '0;
        else if (cnt_step && s1_oh_q[r] && (hit_cnt_q[r] != 32'hFFFF_FFFF))
          hit_cnt_q[r] <= hit_cnt_q[r] + 32'd1;
      end
      if (miss_clr)
        miss_cnt_q <= '0;
      else if (cnt_step && !s1_hit_q && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  // Readback sees the table as it stood before any write in the same cycle
  logic [31:0] rd_d;
  always_comb begin
    rd_d = '0;
    if (!i_rule_addr[8]) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (a_rule == 5'(r)) begin
          case (a_word)
            3'd0: rd_d[KW-1:0] = value_q[r];
            3'd1: rd_d[KW-1:0] = mask_q[r];
            3'd2: begin
              rd_d[31]          = vld_q[r];
              rd_d[15:8]        = shift_q[r];
              rd_d[KEY_NUM-1:0] = keyv_q[r];
            end
            3'd3: rd_d[KB-1:0] = dst_q[r];
            3'd4: rd_d[KB-1:0] = src_q[r];
            3'd5: rd_d[TB-1:0] = nxt_q[r];
            3'd6: rd_d         = hit_cnt_q[r];
            default: ;
          endcase
        end
      end
    end else if (i_rule_addr[7:0] == 8'd0) begin
      rd_d = miss_cnt_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      rvld_q <= i_rule_rden;
      if (i_rule_rden)
        rdata_q <= rd_d;
    end
  end

endmodule

// File: tb/tb_deparser_layer_stream.sv
// Directed bench for deparser_layer_stream: vector table plus stall, config and reset sequences.
module tb_deparser_layer_stream;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [511:0] i_head = '0;
  logic [255:0] i_meta = '0;
  logic [15:0]  i_type_offset = '0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [511:0] o_head;
  logic [255:0] o_meta;
  logic [15:0]  o_type_offset;
  logic         o_miss;
  logic         i_rule_wren = 1'b0;
  logic         i_rule_rden = 1'b0;
  logic [31:0]  i_rule_addr = '0;
  logic [31:0]  i_rule_wdata = '0;
  logic         o_rule_rdata_valid;
  logic [31:0]  o_rule_rdata;

  deparser_layer_stream dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_head(i_head), .i_meta(i_meta), .i_type_offset(i_type_offset),
    .o_valid(o_valid), .i_ready(i_ready), .o_head(o_head), .o_meta(o_meta),
    .o_type_offset(o_type_offset), .o_miss(o_miss),
    .i_rule_wren(i_rule_wren), .i_rule_rden(i_rule_rden), .i_rule_addr(i_rule_addr),
    .i_rule_wdata(i_rule_wdata), .o_rule_rdata_valid(o_rule_rdata_valid),
    .o_rule_rdata(o_rule_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          off0;
    int          off1;
    logic [15:0] t0;
    logic [15:0] t1;
    int          ri0;
    logic [15:0] rv0;
    int          ri1;
    logic [15:0] rv1;
    int          sh;
    logic [15:0] toff;
    logic        miss;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } cfg_t;

  vec_t         vt[7];
  cfg_t         cfg[34];
  logic [255:0] meta_c;
  int           nchk = 0;
  int           nerr = 0;

  function automatic logic [511:0] mk_head(input vec_t v);
    logic [511:0] h;
    for (int w = 0; w < 32; w++) h[511-w*16 -: 16] = 16'hC000 + 16'(w);
    if (v.off0 < 32) h[511-v.off0*16 -: 16] = v.t0;
    if (v.off1 < 32) h[511-v.off1*16 -: 16] = v.t1;
    return h;
  endfunction

  function automatic logic [511:0] exp_head(input vec_t v);
    logic [511:0] h;
    h = mk_head(v);
    if (v.miss) return h;
    if (v.ri0 >= 0) h[511-v.ri0*16 -: 16] = v.rv0;
    if (v.ri1 >= 0) h[511-v.ri1*16 -: 16] = v.rv1;
    if (v.sh >= 32) h = '0;
    else h = h << (v.sh * 16);
    return h;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_rule_wren = 1'b1; i_rule_addr = a; i_rule_wdata = d;
    @(negedge i_clk);
    i_rule_wren = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    @(negedge i_clk);
    i_rule_rden = 1'b1; i_rule_addr = a;
    @(posedge i_clk);
    #1 chk(nm, {o_rule_rdata_valid, o_rule_rdata}, {1'b1, e});
    @(negedge i_clk);
    i_rule_rden = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    i_head = mk_head(v);
    i_meta = meta_c;
    i_type_offset = {8'(v.off1), 8'(v.off0)};
  endtask

  task automatic run_vec(input vec_t v, input int n);
    @(negedge i_clk);
    drive(v);
    i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    chk($sformatf("v%0d_lat_t1", n), o_valid, 1'b0);
    @(posedge i_clk);
    #1;
    chk($sformatf("v%0d_valid_t2", n), o_valid, 1'b1);
    chk($sformatf("v%0d_head", n), o_head, exp_head(v));
    chk($sformatf("v%0d_toff", n), o_type_offset, v.toff);
    chk($sformatf("v%0d_miss", n), o_miss, v.miss);
    chk($sformatf("v%0d_meta", n), o_meta, meta_c);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int  sent, got;
    bit  dropped, acc;
    vec_t mv;

    for (int m = 0; m < 16; m++) meta_c[255-m*16 -: 16] = 16'hA000 + 16'(m);
    meta_c[255 -: 16] = 16'hABCD;

    vt[0] = '{0, 1, 16'h0800, 16'h0006, 2, 16'hABCD, -1, 16'h0, 7, 16'h0302, 1'b0};
    vt[1] = '{4, 9, 16'h86DD, 16'h0011, 3, 16'hA002, -1, 16'h0, 2, 16'h0504, 1'b0};
    vt[2] = '{2, 3, 16'h9999, 16'h9999, -1, 16'h0, -1, 16'h0, 0, 16'h0000, 1'b1};
    vt[3] = '{0, 1, 16'h1111, 16'h2222, -1, 16'h0, -1, 16'h0, 32, 16'h0101, 1'b0};
    vt[4] = '{10, 11, 16'h2222, 16'h3333, 6, 16'hA003, 31, 16'hA00F, 0, 16'h0A09, 1'b0};
    vt[5] = '{40, 12, 16'h0000, 16'h4444, -1, 16'h0, -1, 16'h0, 0, 16'h0B0C, 1'b0};
    vt[6] = '{0, 1, 16'h86DD, 16'h0055, 3, 16'hA002, -1, 16'h0, 2, 16'h0504, 1'b0};

    cfg[0]  = '{32'h000, 32'h0800_0006}; cfg[1]  = '{32'h001, 32'hFFFF_FFFF};
    cfg[2]  = '{32'h002, 32'h8000_0701}; cfg[3]  = '{32'h003, 32'h0000_0002};
    cfg[4]  = '{32'h004, 32'h0000_0000}; cfg[5]  = '{32'h005, 32'h0000_0302};
    cfg[6]  = '{32'h008, 32'h86DD_0000}; cfg[7]  = '{32'h009, 32'hFFFF_0000};
    cfg[8]  = '{32'h00A, 32'h8000_0203}; cfg[9]  = '{32'h00B, 32'h0000_0303};
    cfg[10] = '{32'h00C, 32'h0000_0201}; cfg[11] = '{32'h00D, 32'h0000_0504};
    cfg[12] = '{32'h010, 32'h1111_2222}; cfg[13] = '{32'h011, 32'hFFFF_FFFF};
    cfg[14] = '{32'h012, 32'h8000_2000}; cfg[15] = '{32'h013, 32'h0000_0011};
    cfg[16] = '{32'h014, 32'h0000_0000}; cfg[17] = '{32'h015, 32'h0000_0101};
    cfg[18] = '{32'h018, 32'h86DD_0011}; cfg[19] = '{32'h019, 32'hFFFF_FFFF};
    cfg[20] = '{32'h01A, 32'h8000_0101}; cfg[21] = '{32'h01B, 32'h0000_0000};
    cfg[22] = '{32'h01C, 32'h0000_0000}; cfg[23] = '{32'h01D, 32'h0000_0706};
    cfg[24] = '{32'h020, 32'h2222_3333}; cfg[25] = '{32'h021, 32'hFFFF_FFFF};
    cfg[26] = '{32'h022, 32'hFFFF_00FF}; cfg[27] = '{32'h023, 32'h1F06_0528};
    cfg[28] = '{32'h024, 32'h0F03_1400}; cfg[29] = '{32'h025, 32'h0000_0A09};
    cfg[30] = '{32'h028, 32'h0000_4444}; cfg[31] = '{32'h029, 32'hFFFF_FFFF};
    cfg[32] = '{32'h02A, 32'h8000_0000}; cfg[33] = '{32'h02D, 32'h0000_0B0C};

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_head", o_head, '0);
    chk("rst_o_meta_toff_miss", {o_meta, o_type_offset, o_miss}, '0);
    chk("rst_rdata", {o_rule_rdata_valid, o_rule_rdata}, '0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < 34; i++) wr(cfg[i].a, cfg[i].d);

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Counters and readback
    rd(32'h006, 32'd1, "cnt_rule0");
    rd(32'h00E, 32'd2, "cnt_rule1");
    rd(32'h01E, 32'd0, "cnt_rule3_shadowed");
    rd(32'h016, 32'd1, "cnt_rule2");
    rd(32'h100, 32'd1, "cnt_miss");
    rd(32'h00A, 32'h8000_0203, "rb_rule1_w2");
    rd(32'h022, 32'h8000_000F, "rb_rule4_w2_unused_zero");
    rd(32'h023, 32'h1F06_0528, "rb_rule4_w3");
    rd(32'h007, 32'h0, "rb_reserved_w7");
    rd(32'h101, 32'h0, "rb_global_other");
    wr(32'h00E, 32'hDEAD_BEEF);
    rd(32'h00E, 32'd0, "cnt_rule1_cleared");
    wr(32'h100, 32'h5);
    rd(32'h100, 32'd0, "cnt_miss_cleared");

    // Backpressure: 3 beats offered, i_ready low for 5 cycles
    sent = 0; got = 0; dropped = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge i_clk);
      i_ready = (cyc >= 5);
      if (sent < 3) begin
        drive(vt[sent]);
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (!o_ready) dropped = 1'b1;
      if (o_valid && i_ready) begin
        chk($sformatf("stall_head%0d", got), o_head, exp_head(vt[got]));
        chk($sformatf("stall_toff%0d", got), o_type_offset, vt[got].toff);
        got++;
      end
      acc = i_valid && o_ready;
      @(posedge i_clk);
      if (acc) sent++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    chk("stall_beats_out", got, 3);
    chk("stall_no_dup", o_valid, 1'b0);
    chk("stall_ready_dropped", dropped, 1'b1);

    // Same-cycle write and read of rule 2 w3
    @(negedge i_clk);
    i_rule_wren = 1'b1; i_rule_rden = 1'b1; i_rule_addr = 32'h013; i_rule_wdata = 32'h22;
    @(posedge i_clk);
    #1 chk("wr_rd_same_old", {o_rule_rdata_valid, o_rule_rdata}, {1'b1, 32'h11});
    @(negedge i_clk);
    i_rule_wren = 1'b0; i_rule_rden = 1'b0;
    @(posedge i_clk);
    #1 chk("rdata_valid_pulse", o_rule_rdata_valid, 1'b0);
    rd(32'h013, 32'h22, "wr_rd_same_new");

    wr(32'h040, 32'h1234_5678);
    rd(32'h040, 32'h0, "oor_rule_read");

    // Reset mid-stream
    @(negedge i_clk);
    drive(vt[0]);
    i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    @(posedge i_clk);
    #1 chk("mid_rst_pre_valid", o_valid, 1'b1);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_o_valid", o_valid, 1'b0);
    chk("mid_rst_o_head", o_head, '0);
    @(negedge i_clk);
    i_rst = 1'b0;
    rd(32'h002, 32'h0, "mid_rst_rule0_w2");
    rd(32'h006, 32'h0, "mid_rst_rule0_cnt");
    mv = vt[0];
    mv.miss = 1'b1;
    mv.toff = 16'h0;
    run_vec(mv, 9);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
